// File: rtl/fp8_pkg.sv
// Shared types and helpers for the FP8 matrix loader: FSM states, E4M3 NaN magnitude, lane one-hot.
package fp8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // E4M3 has a single NaN magnitude; the sign bit is ignored.
    localparam logic [6:0] FP8_NAN_BITS = 7'h7F;

    function automatic logic [31:0] lane_mask(input int unsigned idx);
        lane_mask = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/fp8_mat_loader_if.sv
// Element stream plus BRAM write port between a host/stream source (master) and the loader (slave).
interface fp8_mat_loader_if #(
    parameter int MAT_MUL_SIZE = 4,
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4
);
    logic                           s_valid;
    logic [DWIDTH-1:0]              s_data;
    logic                           s_ready;
    logic [AWIDTH-1:0]              bram_addr;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata;
    logic [MASK_WIDTH-1:0]          bram_we;

    modport master (
        output s_valid, s_data,
        input  s_ready, bram_addr, bram_wdata, bram_we
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, bram_addr, bram_wdata, bram_we
    );
endinterface

// File: rtl/fp8_lane_packer.sv
// Pack register and lane decode: next-cycle write data/enables for A (byte) or B (full-word) layout.
// Combinational outputs; the top registers them, so write latency is one cycle from accept.
module fp8_lane_packer
    import fp8_pkg::*;
#(
    parameter int MAT_MUL_SIZE = 4,
    parameter int DWIDTH       = 8,
    parameter int MASK_WIDTH   = 4,
    parameter int CW           = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           clr,
    input  logic                           xfer,
    input  logic                           mode_a,
    input  logic [CW-1:0]                  r,
    input  logic [CW-1:0]                  c,
    input  logic [DWIDTH-1:0]              data,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] wdata,
    output logic [MASK_WIDTH-1:0]          we
);

    logic [MAT_MUL_SIZE*DWIDTH-1:0] pack_q;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] merged;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] lane_word;
    logic [31:0]                    mask_full;

    always_comb begin
        merged                      = pack_q;
        merged[c*DWIDTH +: DWIDTH]  = data;
        lane_word                   = '0;
        lane_word[r*DWIDTH +: DWIDTH] = data;
        mask_full                   = lane_mask(32'(r));
        wdata                       = '0;
        we                          = '0;
        if (xfer) begin
            if (mode_a) begin
                wdata = lane_word;
                we    = mask_full[MASK_WIDTH-1:0];
            end else begin
                // The closing byte of a row bypasses the register so the word goes out complete.
                wdata = merged;
                if (c == CW'(MAT_MUL_SIZE - 1))
                    we = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            pack_q <= '0;
        else if (clr)
            pack_q <= '0;
        else if (xfer && !mode_a)
            pack_q <= merged;
    end

endmodule

// File: rtl/fp8_mat_loader.sv
// Streams row-major FP8 elements into the A (column-packed) or B (row-packed) BRAM; writes land 1 cycle after accept,
// s_ready is high only in LOAD. Optional NaN flag under FP8_LOADER_NAN_CHECK_EN.
module fp8_mat_loader
    import fp8_pkg::*;
#(
    parameter int MAT_MUL_SIZE = 4,
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode_a,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] stride,
    fp8_mat_loader_if.slave   bus,
    output logic              busy,
    output logic              done
`ifdef FP8_LOADER_NAN_CHECK_EN
    ,
    output logic              nan_seen
`endif
);

    localparam int CW = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAT_MUL_SIZE - 1);

    state_t                         state;
    logic [CW-1:0]                  r_q;
    logic [CW-1:0]                  c_q;
    logic [AWIDTH-1:0]              base_q;
    logic [AWIDTH-1:0]              stride_q;
    logic                           mode_q;
    logic                           xfer;
    logic                           clr;
    logic [AWIDTH-1:0]              step_idx;
    logic [AWIDTH-1:0]              wr_addr;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] wdata_nxt;
    logic [MASK_WIDTH-1:0]          we_nxt;

    assign bus.s_ready = (state == LOAD);
    assign xfer        = bus.s_valid && (state == LOAD);
    assign clr         = (state == IDLE) && start;
    // A steps the address per column, B per row; wrap past the top of BRAM is intentional.
    assign step_idx    = mode_q ? AWIDTH'(c_q) : AWIDTH'(r_q);
    assign wr_addr     = base_q + step_idx * stride_q;

    fp8_lane_packer #(
        .MAT_MUL_SIZE (MAT_MUL_SIZE),
        .DWIDTH       (DWIDTH),
        .MASK_WIDTH   (MASK_WIDTH),
        .CW           (CW)
    ) u_packer (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .xfer   (xfer),
        .mode_a (mode_q),
        .r      (r_q),
        .c      (c_q),
        .data   (bus.s_data),
        .wdata  (wdata_nxt),
        .we     (we_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            r_q            <= '0;
            c_q            <= '0;
            base_q         <= '0;
            stride_q       <= '0;
            mode_q         <= 1'b0;
            bus.bram_addr  <= '0;
            bus.bram_wdata <= '0;
            bus.bram_we    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef FP8_LOADER_NAN_CHECK_EN
            nan_seen       <= 1'b0;
`endif
        end else begin
            bus.bram_we <= we_nxt;
            if (|we_nxt) begin
                bus.bram_addr  <= wr_addr;
                bus.bram_wdata <= wdata_nxt;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        stride_q <= stride;
                        mode_q   <= mode_a;
                        r_q      <= '0;
                        c_q      <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
`ifdef FP8_LOADER_NAN_CHECK_EN
                        nan_seen <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
`ifdef FP8_LOADER_NAN_CHECK_EN
                        if (bus.s_data[6:0] == FP8_NAN_BITS)
                            nan_seen <= 1'b1;
`endif
                        if (c_q == LAST) begin
                            c_q <= '0;
                            r_q <= r_q + 1'b1;
                            if (r_q == LAST)
                                state <= FLUSH;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_mat_loader.sv
// Directed bench for fp8_mat_loader: A/B layouts, address wrap, stream gaps, mid-load reset, optional NaN flag.
module tb_fp8_mat_loader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       mode_a;
    logic [9:0] base_addr;
    logic [9:0] stride;
    logic       busy;
    logic       done;
`ifdef FP8_LOADER_NAN_CHECK_EN
    logic       nan_seen;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  elems [16];
    logic [31:0] mem   [0:1023];

    fp8_mat_loader_if #(.MAT_MUL_SIZE(4), .DWIDTH(8), .AWIDTH(10), .MASK_WIDTH(4)) ifc ();

    fp8_mat_loader #(.MAT_MUL_SIZE(4), .DWIDTH(8), .AWIDTH(10), .MASK_WIDTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .mode_a    (mode_a),
        .base_addr (base_addr),
        .stride    (stride),
        .bus       (ifc),
        .busy      (busy),
        .done      (done)
`ifdef FP8_LOADER_NAN_CHECK_EN
        ,
        .nan_seen  (nan_seen)
`endif
    );

    always #5 clk = ~clk;

    // Byte-enabled BRAM image built from whatever the loader writes.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ifc.bram_we[i])
                mem[ifc.bram_addr][8*i +: 8] <= ifc.bram_wdata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_a_rows();
        elems = '{8'd8, 8'd4, 8'd6, 8'd8,  8'd3, 8'd3, 8'd3, 8'd7,
                  8'd5, 8'd2, 8'd1, 8'd6,  8'd9, 8'd1, 8'd0, 8'd5};
    endtask

    task automatic set_b_rows();
        elems = '{8'd1, 8'd1, 8'd3, 8'd0,  8'd0, 8'd1, 8'd4, 8'd3,
                  8'd3, 8'd5, 8'd3, 8'd1,  8'd9, 8'd6, 8'd3, 8'd2};
    endtask

    task automatic check_write(input bit ma, input logic [9:0] base, input logic [9:0] strd, input int p);
        int r, c;
        logic [9:0] ea;
        r = p / 4;
        c = p % 4;
        if (ma) begin
            ea = base + 10'(c) * strd;
            chk("we_a",    64'(ifc.bram_we),    64'd1 << r);
            chk("addr_a",  64'(ifc.bram_addr),  64'(ea));
            chk("wdata_a", 64'(ifc.bram_wdata), 64'(elems[p]) << (8*r));
        end else if (c == 3) begin
            ea = base + 10'(r) * strd;
            chk("we_b",    64'(ifc.bram_we),    64'hF);
            chk("addr_b",  64'(ifc.bram_addr),  64'(ea));
            chk("wdata_b", 64'(ifc.bram_wdata),
                64'({elems[p], elems[p-1], elems[p-2], elems[p-3]}));
        end else begin
            chk("we_b_partial", 64'(ifc.bram_we), 64'h0);
        end
    endtask

    // Runs one load from IDLE. stop_after>0 abandons the stream after that many accepts (start stays high).
    task automatic run_load(input bit ma, input logic [9:0] base, input logic [9:0] strd,
                            input bit gaps, input int stop_after);
        int  idx, pidx;
        bit  pend, finished;
        idx = 0; pidx = 0; pend = 1'b0; finished = 1'b0;
        @(negedge clk);
        start = 1'b1; mode_a = ma; base_addr = base; stride = strd;
        @(negedge clk);
        chk("busy_load",  64'(busy),        64'd1);
        chk("ready_load", 64'(ifc.s_ready), 64'd1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (pend) check_write(ma, base, strd, pidx);
            else      chk("we_idle", 64'(ifc.bram_we), 64'h0);
            if (pend && pidx == 15) begin
                chk("done_early",  64'(done),        64'd0);
                chk("ready_flush", 64'(ifc.s_ready), 64'd0);
                chk("busy_flush",  64'(busy),        64'd1);
            end else if (!pend && idx == 16) begin
                chk("done_rise", 64'(done), 64'd1);
                chk("busy_done", 64'(busy), 64'd0);
                finished = 1'b1;
                break;
            end
            if (stop_after > 0 && idx == stop_after) begin
                ifc.s_valid = 1'b0;
                finished    = 1'b1;
                break;
            end
            if (idx < 16) begin
                ifc.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                ifc.s_data  = ifc.s_valid ? elems[idx] : 8'hA5;
            end else begin
                ifc.s_valid = 1'b0;
            end
            pend = ifc.s_valid && ifc.s_ready;
            pidx = idx;
            if (pend) idx++;
            @(negedge clk);
        end
        ifc.s_valid = 1'b0;
        if (!finished) chk("timeout", 64'd0, 64'd1);
        if (stop_after == 0) begin
            @(negedge clk);
            chk("done_hold", 64'(done), 64'd1);
            start = 1'b0;
            @(negedge clk);
            chk("done_clear", 64'(done), 64'd0);
            chk("busy_idle",  64'(busy), 64'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, 64'(ifc.s_ready),    64'd0);
        chk({tag, "_addr"},  64'(ifc.bram_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(ifc.bram_wdata), 64'd0);
        chk({tag, "_we"},    64'(ifc.bram_we),    64'd0);
        chk({tag, "_busy"},  64'(busy),           64'd0);
        chk({tag, "_done"},  64'(done),           64'd0);
    endtask

    task automatic check_a_image(input string tag, input logic [9:0] base);
        chk({tag, "_w0"}, 64'(mem[base + 10'd0]), 64'h09050308);
        chk({tag, "_w1"}, 64'(mem[base + 10'd1]), 64'h01020304);
        chk({tag, "_w2"}, 64'(mem[base + 10'd2]), 64'h00010306);
        chk({tag, "_w3"}, 64'(mem[base + 10'd3]), 64'h05060708);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mode_a = 1'b0;
        base_addr = '0; stride = '0;
        ifc.s_valid = 1'b0; ifc.s_data = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;

        // Mode A, contiguous
        set_a_rows();
        run_load(1'b1, 10'h000, 10'd1, 1'b0, 0);
        check_a_image("a_plain", 10'h000);

        // Mode B, contiguous
        set_b_rows();
        run_load(1'b0, 10'h000, 10'd1, 1'b0, 0);
        chk("b_w0", 64'(mem[10'h000]), 64'h00030101);
        chk("b_w1", 64'(mem[10'h001]), 64'h03040100);
        chk("b_w2", 64'(mem[10'h002]), 64'h01030503);
        chk("b_w3", 64'(mem[10'h003]), 64'h02030609);

        // Mode B with address wrap past the top
        run_load(1'b0, 10'h3FE, 10'd1, 1'b0, 0);
        chk("wrap_w0", 64'(mem[10'h3FE]), 64'h00030101);
        chk("wrap_w1", 64'(mem[10'h3FF]), 64'h03040100);
        chk("wrap_w2", 64'(mem[10'h000]), 64'h01030503);
        chk("wrap_w3", 64'(mem[10'h001]), 64'h02030609);

        // Mode A with random s_valid gaps
        set_a_rows();
        run_load(1'b1, 10'h100, 10'd1, 1'b1, 0);
        check_a_image("a_gaps", 10'h100);

        // Reset after 7 accepts, then a fresh load
        run_load(1'b1, 10'h200, 10'd1, 1'b0, 7);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        resetn = 1'b1;
        run_load(1'b1, 10'h200, 10'd1, 1'b0, 0);
        check_a_image("a_after_reset", 10'h200);

`ifdef FP8_LOADER_NAN_CHECK_EN
        set_a_rows();
        elems[9] = 8'hFF;
        run_load(1'b1, 10'h300, 10'd1, 1'b0, 0);
        chk("nan_set",  64'(nan_seen),     64'd1);
        chk("nan_data", 64'(mem[10'h301]), 64'h01FF0304);
        set_a_rows();
        run_load(1'b1, 10'h300, 10'd1, 1'b0, 0);
        chk("nan_clear", 64'(nan_seen), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
